// File: rtl/pc_pkg.sv
// Shared constants for the PC / return-address-stack unit: ps opcodes and PC step.
package pc_pkg;

  typedef enum logic [2:0] {
    PS_HOLD = 3'b000,
    PS_INC  = 3'b001,
    PS_BR   = 3'b010,
    PS_JMP  = 3'b011,
    PS_CALL = 3'b100,
    PS_RET  = 3'b101,
    PS_RSV6 = 3'b110,
    PS_RSV7 = 3'b111
  } ps_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Command/data link between the PC mux and its return-address stack.
// push/pop are single-cycle commands taken on the rising edge; pop is only issued when empty=0.
interface pc_ras_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] rdata;
  logic              full;
  logic              empty;

  modport master (output push, pop, wdata, input rdata, full, empty);
  modport slave  (input push, pop, wdata, output rdata, full, empty);
endinterface

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input logic           clock,
  input logic           reset,
  pc_ras_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // wr_ptr points at the next free slot; the top of stack sits one below it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end else if (bus.pop) begin
      wr_ptr <= wr_ptr - 1'b1;
      count  <= count - 1'b1;
    end
  end

  // Contents are never cleared: count=0 makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (reset && bus.push) mem[wr_ptr] <= bus.wdata;
  end

  assign bus.rdata = mem[PTR_W'(wr_ptr - 1'b1)];
  assign bus.empty = (count == '0);
  assign bus.full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with hold/inc/branch/jump/call/return selection and a return-address stack.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                OFF_W          = 30,
  parameter int                RAS_DEPTH      = 8,
  parameter logic [ADDR_W-1:0] PC_RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        ps,
  input  logic [OFF_W-1:0]  in,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] q,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              illegal_op
);
  localparam int EXT_W = (ADDR_W > OFF_W + 2) ? ADDR_W : OFF_W + 2;

  pc_ras_unit_if #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) ras_bus ();

  ras_stack #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_stack (
    .clock (clock),
    .reset (reset),
    .bus   (ras_bus)
  );

  logic [EXT_W-1:0]  br_ext;
  logic [EXT_W-1:0]  jmp_ext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] q_nxt;
  logic              set_ovf;
  logic              set_unf;
  logic              ill_nxt;

  // Word offsets become byte offsets: branch sign-extends, jump zero-extends.
  assign br_ext  = EXT_W'($signed({in, 2'b00}));
  assign jmp_ext = EXT_W'({in, 2'b00});
  assign pc_inc  = q + ADDR_W'(PC_STEP);
  assign br_tgt  = pc_inc + ADDR_W'(br_ext);
  assign jmp_tgt = ADDR_W'(jmp_ext);

  always_comb begin
    q_nxt         = q;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    ill_nxt       = 1'b0;
    ras_bus.push  = 1'b0;
    ras_bus.pop   = 1'b0;
    ras_bus.wdata = pc_inc;
    if (!stall) begin
      case (ps_e'(ps))
        PS_HOLD: q_nxt = q;
        PS_INC:  q_nxt = pc_inc;
        PS_BR:   q_nxt = br_tgt;
        PS_JMP:  q_nxt = jmp_tgt;
        PS_CALL: begin
          ras_bus.push = 1'b1;
          set_ovf      = ras_bus.full;
          q_nxt        = jmp_tgt;
        end
        PS_RET: begin
          if (ras_bus.empty) begin
            set_unf = 1'b1;
            q_nxt   = pc_inc;
          end else begin
            ras_bus.pop = 1'b1;
            q_nxt       = ras_bus.rdata;
          end
        end
        default: begin
          ill_nxt = 1'b1;
          q_nxt   = pc_inc;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q          <= PC_RESET_VALUE;
      ras_ovf    <= 1'b0;
      ras_unf    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      q          <= q_nxt;
      ras_ovf    <= set_ovf | (ras_ovf & ~clr_err);
      ras_unf    <= set_unf | (ras_unf & ~clr_err);
      illegal_op <= ill_nxt;
    end
  end

  assign ras_empty = ras_bus.empty;
  assign ras_full  = ras_bus.full;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus randomized traffic against a queue model.
module tb_pc_ras_unit;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = 30;
  localparam int DEPTH  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic [2:0]        ps = 3'b000;
  logic [OFF_W-1:0]  in = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] q;
  logic              ras_empty, ras_full, ras_ovf, ras_unf, illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC value, stack as a queue (back = newest), flags.
  logic [ADDR_W-1:0] m_q = '0;
  logic [ADDR_W-1:0] m_stk[$];
  logic              m_ovf = 1'b0, m_unf = 1'b0, m_ill = 1'b0;

  pc_ras_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH), .PC_RESET_VALUE('0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .ps(ps), .in(in), .clr_err(clr_err),
    .q(q), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic model_edge();
    logic so, su;
    logic signed [ADDR_W-1:0] off;
    so = 1'b0;
    su = 1'b0;
    if (!reset) begin
      m_q = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_ill = 1'b0;
    end else begin
      m_ill = 1'b0;
      if (!stall) begin
        case (ps)
          3'd0: ;
          3'd1: m_q = m_q + 4;
          3'd2: begin
            off = {{(ADDR_W-OFF_W){in[OFF_W-1]}}, in};
            m_q = m_q + 4 + (off * 4);
          end
          3'd3: m_q = {in, 2'b00};
          3'd4: begin
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_front());
              so = 1'b1;
            end
            m_stk.push_back(m_q + 4);
            m_q = {in, 2'b00};
          end
          3'd5: begin
            if (m_stk.size() == 0) begin
              m_q = m_q + 4;
              su = 1'b1;
            end else m_q = m_stk.pop_back();
          end
          default: begin
            m_q = m_q + 4;
            m_ill = 1'b1;
          end
        endcase
      end
      m_ovf = so ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_unf = su ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic [2:0] p,
                       input logic [OFF_W-1:0] d, input logic c);
    @(negedge clock);
    reset = r; stall = s; ps = p; in = d; clr_err = c;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 3'd4, 30'h55, 1'b0);
    n_cmp++; if (q !== 32'h0) begin n_err++; $display("FAIL reset_q: got %h want %h", q, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_err++;
      $display("FAIL reset_occ: empty=%b full=%b want 1 0", ras_empty, ras_full); end
    n_cmp++; if ({ras_ovf, ras_unf, illegal_op} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {ras_ovf, ras_unf, illegal_op}); end
  endtask

  task automatic test_inc();
    logic [ADDR_W-1:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle(1'b1, 1'b0, 3'd1, '0, 1'b0);
      n_cmp++; if (q !== exp_pc[i]) begin n_err++;
        $display("FAIL inc_q[%0d]: got %h want %h", i, q, exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    cycle(1'b1, 1'b0, 3'd3, 30'h40, 1'b0);
    cycle(1'b1, 1'b0, 3'd2, 30'h3FFFFFFE, 1'b0);
    n_cmp++; if (q !== 32'h0FC) begin n_err++; $display("FAIL branch_neg: got %h want %h", q, 32'h0FC); end
    cycle(1'b1, 1'b0, 3'd3, 30'h40, 1'b0);
    cycle(1'b1, 1'b0, 3'd2, 30'h3, 1'b0);
    n_cmp++; if (q !== 32'h110) begin n_err++; $display("FAIL branch_pos: got %h want %h", q, 32'h110); end
  endtask

  task automatic test_call_ret();
    cycle(1'b1, 1'b0, 3'd3, 30'h10, 1'b0);
    cycle(1'b1, 1'b0, 3'd4, 30'h100, 1'b0);
    n_cmp++; if (q !== 32'h400 || ras_empty !== 1'b0) begin n_err++;
      $display("FAIL call_q: got %h empty=%b want 400 empty=0", q, ras_empty); end
    cycle(1'b1, 1'b0, 3'd5, '0, 1'b0);
    n_cmp++; if (q !== 32'h44 || ras_empty !== 1'b1) begin n_err++;
      $display("FAIL ret_q: got %h empty=%b want 44 empty=1", q, ras_empty); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] ret_addr[$];
    for (int i = 0; i < DEPTH + 1; i++) begin
      ret_addr.push_back(m_q + 4);
      cycle(1'b1, 1'b0, 3'd4, OFF_W'(30'h400 + i * 16), 1'b0);
    end
    n_cmp++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1) begin n_err++;
      $display("FAIL ovf_flags: full=%b ovf=%b want 1 1", ras_full, ras_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 3'd5, '0, 1'b0);
      n_cmp++; if (q !== ret_addr[DEPTH - i]) begin n_err++;
        $display("FAIL ovf_ret[%0d]: got %h want %h", i, q, ret_addr[DEPTH - i]); end
    end
    cycle(1'b1, 1'b0, 3'd5, '0, 1'b0);
    n_cmp++; if (q !== ret_addr[1] + 4 || ras_unf !== 1'b1 || ras_empty !== 1'b1) begin n_err++;
      $display("FAIL unf_ret: q=%h unf=%b empty=%b want %h 1 1", q, ras_unf, ras_empty, ret_addr[1] + 4); end
    // Underflow again while clearing: the new event must win.
    cycle(1'b1, 1'b0, 3'd5, '0, 1'b1);
    n_cmp++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b0) begin n_err++;
      $display("FAIL set_wins: unf=%b ovf=%b want 1 0", ras_unf, ras_ovf); end
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b1);
    n_cmp++; if (ras_unf !== 1'b0 || ras_ovf !== 1'b0) begin n_err++;
      $display("FAIL clr_err: unf=%b ovf=%b want 0 0", ras_unf, ras_ovf); end
  endtask

  task automatic test_illegal_stall();
    logic [ADDR_W-1:0] pc0;
    pc0 = m_q;
    cycle(1'b1, 1'b0, 3'd6, '0, 1'b0);
    n_cmp++; if (q !== pc0 + 4 || illegal_op !== 1'b1) begin n_err++;
      $display("FAIL illegal: q=%h ill=%b want %h 1", q, illegal_op, pc0 + 4); end
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0);
    n_cmp++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_pulse: got %b want 0", illegal_op); end
    cycle(1'b1, 1'b1, 3'd7, '0, 1'b0);
    cycle(1'b1, 1'b1, 3'd4, 30'h99, 1'b0);
    n_cmp++; if (q !== pc0 + 4 || ras_empty !== 1'b1 || illegal_op !== 1'b0) begin n_err++;
      $display("FAIL stall: q=%h empty=%b ill=%b want %h 1 0", q, ras_empty, illegal_op, pc0 + 4); end
  endtask

  task automatic test_reset_mid_call();
    cycle(1'b1, 1'b0, 3'd3, 30'h200, 1'b0);
    cycle(1'b0, 1'b0, 3'd4, 30'h300, 1'b0);
    n_cmp++; if (q !== 32'h0 || ras_empty !== 1'b1) begin n_err++;
      $display("FAIL rst_call: q=%h empty=%b want 0 1", q, ras_empty); end
    cycle(1'b1, 1'b0, 3'd5, '0, 1'b0);
    n_cmp++; if (q !== 32'h4 || ras_unf !== 1'b1) begin n_err++;
      $display("FAIL rst_nopush: q=%h unf=%b want 4 1", q, ras_unf); end
  endtask

  task automatic test_random();
    logic r, s, c;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 10);
      c = ($urandom_range(0, 99) < 8);
      // Bias toward calls/returns so the stack fills and drains repeatedly.
      cycle(r, s, 3'($urandom_range(0, 99) < 50 ? $urandom_range(4, 5) : $urandom_range(0, 7)),
            OFF_W'($urandom), c);
      n_cmp++;
      if (q !== m_q || ras_empty !== (m_stk.size() == 0) || ras_full !== (m_stk.size() == DEPTH) ||
          ras_ovf !== m_ovf || ras_unf !== m_unf || illegal_op !== m_ill) begin
        n_err++;
        $display("FAIL random[%0d]: q=%h e=%b f=%b o=%b u=%b i=%b want q=%h e=%b f=%b o=%b u=%b i=%b",
                 i, q, ras_empty, ras_full, ras_ovf, ras_unf, illegal_op,
                 m_q, m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_unf, m_ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_branch();
    test_call_ret();
    test_overflow();
    test_illegal_stall();
    test_reset_mid_call();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
